gate_bist_ctrl: RTL
===================

# gate_bist_ctrl

Built-in self-test sequencer for the demux-based universal logic gates (NAND, NOR and derived gates). On `start` it drives the gate under test through its four input vectors in the order 00, 01, 10, 11. After each vector it waits a programmable settle interval, then compares the gate output against the expected truth-table value for the selected gate type. It sits between a test controller (or top-level self-test) and one gate instance, and reports pass/fail plus the first failing vector.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: idle cycles between applying a vector and sampling `dut_y`; legal range 0–15.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a test run; sampled only in IDLE.
- `op`  input  3  gate type, latched on accepted `start`: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6–7 reserved.
- `dut_a`  output  1  registered input A to the gate under test.
- `dut_b`  output  1  registered input B to the gate under test.
- `dut_y`  input  1  gate-under-test output.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse at the end of a run.
- `pass`  output  1  result of the last run; valid from `done` until the next accepted `start`.
- `fail_vec`  output  2  index {a,b} of the first mismatching vector; 0 when `pass`=1.
- `err_op`  output  1  last `start` carried a reserved `op`.

## Operation
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- **IDLE**
  - `start`=1 with `op` 0–5: latch `op`, vector index `vec`=0, clear `pass`/`fail_vec`/`err_op`, go to APPLY.
  - `start`=1 with `op` 6–7: set `err_op`=1, `pass`=0, `fail_vec`=0, go to DONE with no vectors applied.
- **APPLY** (1 cycle): `{dut_a,dut_b}` register is loaded with `vec` on entry, so the vector is visible throughout APPLY.
  - Go to SETTLE if `SETTLE_CYCLES`>0, otherwise go to CHECK.
- **SETTLE**: 4-bit counter runs from 0 to `SETTLE_CYCLES`-1, then go to CHECK. Inputs to the gate are held stable.
- **CHECK** (1 cycle): compare `dut_y` against `expected(op_latched, vec)`, computed combinationally.
  - Mismatch: `fail_vec`=`vec`, `pass`=0, go to DONE (early abort).
  - Match and `vec`=3: `pass`=1, go to DONE.
  - Match and `vec`<3: `vec`+1, go to APPLY.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- `start` is ignored in every state except IDLE, including DONE.
- `dut_a`/`dut_b` keep the last applied vector after a run. They return to 0 only on reset.
- Changing `op` during a run has no effect; the latched copy is used.

## Timing
- Reset values: `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `fail_vec`=0, `err_op`=0, state IDLE, counters 0.
- Reset asserted mid-run: reset values appear at the next edge and the run is abandoned with no `done` pulse.
- Cycle numbering: `start` is sampled at edge 0, and cycle 1 is the first APPLY.
- Vector k is sampled in CHECK at cycle (k+1)·(S+2), where S=`SETTLE_CYCLES`.
- Full passing run: `done` is high in cycle 4·(S+2)+1.
  - S=2: cycle 17.
  - S=0: cycle 9.
- Failure at vector k: `done` is high in cycle (k+1)·(S+2)+1.
- Reserved `op`: `done` is high in cycle 1.
- `busy` goes high in cycle 1 and stays high through the DONE cycle.
- `pass`, `fail_vec` and `err_op` update at the same edge that enters DONE.

## Test plan
- **NAND pass**: `op`=0, S=2, `dut_y` driven by a correct NAND model → vectors 00,01,10,11 applied in order; `done` at cycle 17; `pass`=1, `fail_vec`=0, `err_op`=0.
- **Stuck output**: `op`=1 (NOR), `dut_y` stuck at 1 → first mismatch at vector 01; `done` at cycle 9; `pass`=0, `fail_vec`=1.
- **Reserved op**: `start` with `op`=7 → `done` at cycle 1; `err_op`=1, `pass`=0; `dut_a`/`dut_b` unchanged.
- **Zero settle**: S=0, `op`=4 (XOR), correct model → `done` at cycle 9, `pass`=1. Apply `start` pulses while `busy`=1 → run length unchanged; no second run starts after DONE unless `start` is re-asserted in IDLE.
- **Reset mid-run**: `op`=5 (XNOR), S=2, assert `rst` at cycle 6 → next edge gives all outputs 0 and state IDLE, with no `done` pulse. A new `start` then runs normally to `pass`=1.
- **Last-vector fault**: `op`=2 (AND) with `dut_y` wrong only for vector 11 → `done` at cycle 17; `fail_vec`=3, `pass`=0.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for a single two-input universal logic gate.
// Walks vectors 00..11, waits a settle interval, checks the output and reports pass or the first failing vector.
module gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_vec,
  output logic       err_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // Unused when SETTLE_CYCLES is 0, since SETTLE is then never entered.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [1:0] ab_q, ab_d;
  logic       pass_q, pass_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic       err_op_q, err_op_d;

  function automatic logic expected_y(input logic [2:0] gate_op, input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    case (gate_op)
      3'd0:    expected_y = ~(a & b);
      3'd1:    expected_y = ~(a | b);
      3'd2:    expected_y = a & b;
      3'd3:    expected_y = a | b;
      3'd4:    expected_y = a ^ b;
      3'd5:    expected_y = ~(a ^ b);
      default: expected_y = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    ab_d       = ab_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    err_op_d   = err_op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d     = 1'b0;
          fail_vec_d = 2'd0;
          if (op <= 3'd5) begin
            op_d     = op;
            vec_d    = 2'd0;
            ab_d     = 2'd0;
            err_op_d = 1'b0;
            state_d  = S_APPLY;
          end else begin
            err_op_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_APPLY: begin
        cnt_d = 4'd0;
        if (SETTLE_CYCLES > 0) state_d = S_SETTLE;
        else                   state_d = S_CHECK;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      S_CHECK: begin
        if (dut_y != expected_y(op_q, vec_q)) begin
          fail_vec_d = vec_q;
          pass_d     = 1'b0;
          state_d    = S_DONE;
        end else if (vec_q == 2'd3) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          // The next vector is loaded on entry to APPLY so it is visible for the whole cycle.
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= 4'd0;
      op_q       <= 3'd0;
      ab_q       <= 2'd0;
      pass_q     <= 1'b0;
      fail_vec_q <= 2'd0;
      err_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      ab_q       <= ab_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      err_op_q   <= err_op_d;
    end
  end

  assign dut_a    = ab_q[1];
  assign dut_b    = ab_q[0];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;
  assign err_op   = err_op_q;

endmodule
